// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, line levels and baud-rate helper.
// Used by both the transmit and receive ends of the serial link.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    // Integer clk cycles per bit; truncates (50 MHz / 9600 -> 5208).
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick
// on the last cycle of each bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt <= '0;
        else if (clr)   cnt <= '0;
        else if (en)    cnt <= tick ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/uart_tx_frame.sv
// 8N1 (or 8N2) UART transmitter with a one-entry holding register, so the
// next byte can queue during the current frame and frames go out gap-free.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [2:0] bit_q, bit_d;
    logic       tick, accept, load;

    assign tx_ready = !hold_full_q;
    assign accept   = tx_valid && !hold_full_q;

    // Counter sits cleared in IDLE so each fresh frame starts on a bit
    // boundary; across STOP->START it keeps wrapping, so no drift.
    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == IDLE),
        .en    (state_q != IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_q       <= bit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_d       = bit_q;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (hold_full_q) begin
                            load    = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // load needs holding full, accept needs it empty: never both.
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    // Line driven from the registered state, one cycle behind the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx   <= LINE_IDLE;
            busy <= 1'b0;
        end else begin
            case (state_q)
                START:   tx <= START_LVL;
                DATA:    tx <= shift_q[0];
                default: tx <= LINE_IDLE;
            endcase
            busy <= (state_q != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: two fast instances (16 clk/bit, 1 and 2
// stop bits) and one at the default 5208 clk/bit.
module tb_uart_tx_frame;

    localparam int CPB = 16;
    localparam int DEF_CPB = 5208;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_data, b_data, c_data;
    logic       a_valid, b_valid, c_valid;
    logic       a_ready, b_ready, c_ready;
    logic       a_tx, b_tx, c_tx;
    logic       a_busy, b_busy, c_busy;

    int checks = 0;
    int errors = 0;

    logic cap_tx   [0:599];
    logic cap_busy [0:599];
    logic cap_rdy  [0:599];

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .tx(a_tx), .busy(a_busy));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .tx(b_tx), .busy(b_busy));

    uart_tx_frame u_c (
        .clk(clk), .rst_n(rst_n), .tx_data(c_data), .tx_valid(c_valid),
        .tx_ready(c_ready), .tx(c_tx), .busy(c_busy));

    // Expected line level for frame bit b: start, 8 data LSB-first, stops.
    function automatic logic fbit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    // Sample one instance per cycle at negedges, starting at the current one.
    task automatic capture(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            cap_tx[i]   = (sel == 0) ? a_tx    : b_tx;
            cap_busy[i] = (sel == 0) ? a_busy  : b_busy;
            cap_rdy[i]  = (sel == 0) ? a_ready : b_ready;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int bad;
        rst_n = 1'b0;
        a_valid = 0; b_valid = 0; c_valid = 0;
        a_data = '0; b_data = '0; c_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_a: tx=%b busy=%b ready=%b, want 1 0 1", a_tx, a_busy, a_ready);
        end
        checks++;
        if (c_tx !== 1'b1 || c_busy !== 1'b0 || c_ready !== 1'b1 || b_tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_bc: c tx=%b busy=%b ready=%b b tx=%b, want 1 0 1 1",
                     c_tx, c_busy, c_ready, b_tx);
        end
        rst_n = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_hold: %0d bad cycles of 200, want 0", bad);
        end
    endtask

    task automatic test_single;
        int nbusy;
        @(negedge clk);
        a_data = 8'h35; a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        checks++;
        if (a_ready !== 1'b0 || a_tx !== 1'b1) begin
            errors++;
            $display("FAIL single_n: ready=%b tx=%b, want 0 1", a_ready, a_tx);
        end
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || a_tx !== 1'b1) begin
            errors++;
            $display("FAIL single_n1: ready=%b tx=%b, want 1 1", a_ready, a_tx);
        end
        @(negedge clk);
        capture(0, 161);
        nbusy = 0;
        for (int i = 0; i < 160; i++) begin
            if (cap_busy[i] === 1'b1) nbusy++;
            checks++;
            if (cap_tx[i] !== fbit(8'h35, i / CPB)) begin
                errors++;
                $display("FAIL single_bit: cycle %0d tx=%b want %b", i, cap_tx[i], fbit(8'h35, i / CPB));
            end
        end
        checks++;
        if (nbusy !== 160 || cap_busy[160] !== 1'b0 || cap_tx[160] !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: busy cycles=%0d end busy=%b tx=%b, want 160 0 1",
                     nbusy, cap_busy[160], cap_tx[160]);
        end
    endtask

    task automatic test_back_to_back;
        int bad_rdy, bad_busy;
        @(negedge clk);
        a_data = 8'h35; a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        fork
            capture(0, 330);
            begin
                repeat (50) @(negedge clk);
                a_data = 8'h02; a_valid = 1'b1;
                @(posedge clk);
                @(negedge clk);
                a_valid = 1'b0;
            end
        join
        for (int i = 0; i < 320; i++) begin
            checks++;
            if (cap_tx[i] !== fbit((i < 160) ? 8'h35 : 8'h02, (i % 160) / CPB)) begin
                errors++;
                $display("FAIL b2b_bit: cycle %0d tx=%b", i, cap_tx[i]);
            end
        end
        bad_rdy = 0;
        for (int i = 51; i < 159; i++) if (cap_rdy[i] !== 1'b0) bad_rdy++;
        checks++;
        if (bad_rdy !== 0 || cap_rdy[159] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: %0d early-ready cycles, ready at frame end=%b, want 0 1",
                     bad_rdy, cap_rdy[159]);
        end
        bad_busy = 0;
        for (int i = 0; i < 320; i++) if (cap_busy[i] !== 1'b1) bad_busy++;
        checks++;
        if (bad_busy !== 0 || cap_busy[320] !== 1'b0 || cap_tx[320] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy: %0d gap cycles, end busy=%b tx=%b, want 0 0 1",
                     bad_busy, cap_busy[320], cap_tx[320]);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] bytes [0:2];
        int s, bad;
        bytes[0] = 8'hA5; bytes[1] = 8'hFF; bytes[2] = 8'h00;
        @(negedge clk);
        fork
            capture(0, 540);
            begin
                a_valid = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    int t;
                    a_data = bytes[k];
                    t = 0;
                    while (a_ready !== 1'b1 && t < 1000) begin
                        @(negedge clk);
                        t++;
                    end
                    checks++;
                    if (a_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL bp_wait: byte %0d never accepted, ready=%b", k, a_ready);
                    end
                    @(posedge clk);
                    @(negedge clk);
                end
                a_valid = 1'b0;
            end
        join
        s = 0;
        while (s < 500 && cap_tx[s] !== 1'b0) s++;
        checks++;
        if (s !== 3) begin
            errors++;
            $display("FAIL bp_latency: first start at sample %0d, want 3", s);
        end
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < 10; b++) begin
                checks++;
                if (cap_tx[s + 160*k + CPB*b + 8] !== fbit(bytes[k], b)) begin
                    errors++;
                    $display("FAIL bp_bit: frame %0d bit %0d tx=%b want %b",
                             k, b, cap_tx[s + 160*k + CPB*b + 8], fbit(bytes[k], b));
                end
            end
        end
        bad = 0;
        for (int i = s + 480; i < 540; i++) if (cap_tx[i] !== 1'b1) bad++;
        checks++;
        if (bad !== 0 || cap_busy[539] !== 1'b0) begin
            errors++;
            $display("FAIL bp_extra: %0d low cycles after 3 frames, busy=%b, want 0 0", bad, cap_busy[539]);
        end
    endtask

    task automatic test_stop2;
        int nbusy;
        @(negedge clk);
        b_data = 8'h80; b_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        capture(1, 177);
        nbusy = 0;
        for (int i = 0; i < 176; i++) begin
            if (cap_busy[i] === 1'b1) nbusy++;
            checks++;
            if (cap_tx[i] !== fbit(8'h80, i / CPB)) begin
                errors++;
                $display("FAIL stop2_bit: cycle %0d tx=%b want %b", i, cap_tx[i], fbit(8'h80, i / CPB));
            end
        end
        checks++;
        if (nbusy !== 176 || cap_busy[176] !== 1'b0 || cap_tx[176] !== 1'b1) begin
            errors++;
            $display("FAIL stop2_len: busy cycles=%0d end busy=%b tx=%b, want 176 0 1",
                     nbusy, cap_busy[176], cap_tx[176]);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        @(negedge clk);
        a_data = 8'h00; a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        repeat (20) @(negedge clk);
        a_data = 8'hFF; a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (a_tx !== 1'b0 || a_ready !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: tx=%b ready=%b busy=%b, want 0 0 1", a_tx, a_ready, a_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_async: tx=%b busy=%b ready=%b, want 1 0 1", a_tx, a_busy, a_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (a_tx !== 1'b1 || a_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL mid_resume: %0d non-idle cycles after release, want 0", bad);
        end
    endtask

    task automatic test_default;
        logic [9:0] rx;
        int t, nbusy;
        @(negedge clk);
        c_data = 8'h5A; c_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c_valid = 1'b0;
        t = 0;
        while (c_tx !== 1'b0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (c_tx !== 1'b0) begin
            errors++;
            $display("FAIL def_start: tx=%b after %0d cycles, want 0", c_tx, t);
        end
        rx = '0;
        nbusy = 0;
        for (int i = 0; i < 10 * DEF_CPB; i++) begin
            if (i % DEF_CPB == DEF_CPB / 2) rx[i / DEF_CPB] = c_tx;
            if (c_busy === 1'b1) nbusy++;
            @(negedge clk);
        end
        checks++;
        if (rx[0] !== 1'b0 || rx[8:1] !== 8'h5A || rx[9] !== 1'b1) begin
            errors++;
            $display("FAIL def_loopback: start=%b data=%h stop=%b, want 0 5a 1", rx[0], rx[8:1], rx[9]);
        end
        checks++;
        if (nbusy !== 52080 || c_busy !== 1'b0 || c_tx !== 1'b1) begin
            errors++;
            $display("FAIL def_len: busy cycles=%0d end busy=%b tx=%b, want 52080 0 1", nbusy, c_busy, c_tx);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        repeat (5) @(negedge clk);
        test_back_to_back;
        repeat (5) @(negedge clk);
        test_backpressure;
        repeat (5) @(negedge clk);
        test_stop2;
        repeat (5) @(negedge clk);
        test_reset_mid;
        test_default;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
